// File: rtl/srio_swrite_chunker_pkg.sv
// Shared SRIO SWRITE constants and FSM encoding used by the chunker and the packer.
package srio_swrite_chunker_pkg;

  localparam int SRIO_MAX_PAYLOAD_BYTES = 256;
  localparam int SRIO_BEAT_BYTES        = 8;
  localparam int SRIO_MAX_BEATS         = SRIO_MAX_PAYLOAD_BYTES / SRIO_BEAT_BYTES;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  // A zero or oversized request means "use the hard limit".
  function automatic logic [5:0] eff_limit(input logic [5:0] cfg, input logic [5:0] max_l);
    return ((cfg == 6'd0) || (cfg > max_l)) ? max_l : cfg;
  endfunction

endpackage

// File: rtl/srio_swrite_chunker_skid_buf.sv
// Two-entry registered skid buffer for AXIS; ready depends on occupancy only.
module axis_skid_buf #(
  parameter int WIDTH = 66
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] skid_q;
  logic [1:0]       cnt_q;
  logic             rdy_en_q;
  logic             push;
  logic             pop;

  // rdy_en_q keeps s_ready low for the first cycle after reset release.
  assign s_ready = rdy_en_q && (cnt_q != 2'd2);
  assign m_valid = (cnt_q != 2'd0);
  assign m_data  = head_q;
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      skid_q   <= '0;
      cnt_q    <= 2'd0;
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= s_data;
          else               skid_q <= s_data;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd2) head_q <= skid_q;
          cnt_q <= cnt_q - 2'd1;
        end
        // Push with pop only happens at occupancy 1 (full blocks push).
        2'b11: head_q <= s_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/srio_swrite_chunker.sv
// Splits long AXIS DMA transfers into SRIO-sized segments, marking TLAST per segment.
//   state     | meaning
//   ST_IDLE   | next accepted beat starts a segment; limit latched then
//   ST_IN_PKT | mid-segment, beat_cnt beats already accepted
module srio_swrite_chunker
  import srio_swrite_chunker_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int MAX_BEATS  = SRIO_MAX_BEATS,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESETN,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  input  logic                  S_AXIS_TLAST,
  output logic                  S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  input  logic [5:0]            cfg_max_beats,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  xfer_done
);

  localparam logic [5:0] MAX_L = 6'(MAX_BEATS);

  state_t                state_q, state_d;
  logic [5:0]            beat_cnt_q, beat_cnt_d;
  logic [5:0]            lim_q, lim_d;
  logic [5:0]            cfg_lim;
  logic                  in_fire;
  logic                  seg_last;
  logic                  out_fire;
  logic                  out_eot;
  logic                  s_ready;
  logic                  m_valid;
  logic [DATA_WIDTH+1:0] buf_in;
  logic [DATA_WIDTH+1:0] buf_out;

  assign cfg_lim = eff_limit(cfg_max_beats, MAX_L);
  assign in_fire = S_AXIS_TVALID && s_ready;

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    lim_d      = lim_q;
    seg_last   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        seg_last = (cfg_lim == 6'd1) || S_AXIS_TLAST;
        if (in_fire) begin
          lim_d = cfg_lim;
          if (!seg_last) begin
            state_d    = ST_IN_PKT;
            beat_cnt_d = 6'd1;
          end
        end
      end
      ST_IN_PKT: begin
        seg_last = (beat_cnt_q == (lim_q - 6'd1)) || S_AXIS_TLAST;
        if (in_fire) begin
          if (seg_last) begin
            state_d    = ST_IDLE;
            beat_cnt_d = 6'd0;
          end else begin
            beat_cnt_d = beat_cnt_q + 6'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q    <= ST_IDLE;
      beat_cnt_q <= 6'd0;
      lim_q      <= MAX_L;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      lim_q      <= lim_d;
    end
  end

  // Each buffered beat carries {eot, segment tlast, data}.
  assign buf_in = {S_AXIS_TLAST, seg_last, S_AXIS_TDATA};

  axis_skid_buf #(
    .WIDTH(DATA_WIDTH + 2)
  ) u_skid (
    .clk    (AXIS_ACLK),
    .rst_n  (AXIS_ARESETN),
    .s_data (buf_in),
    .s_valid(S_AXIS_TVALID),
    .s_ready(s_ready),
    .m_data (buf_out),
    .m_valid(m_valid),
    .m_ready(M_AXIS_TREADY)
  );

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TVALID = m_valid;
  assign M_AXIS_TDATA  = buf_out[DATA_WIDTH-1:0];
  assign M_AXIS_TLAST  = buf_out[DATA_WIDTH];
  assign out_eot       = buf_out[DATA_WIDTH+1];
  assign out_fire      = m_valid && M_AXIS_TREADY;

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      pkt_count <= '0;
      xfer_done <= 1'b0;
    end else begin
      xfer_done <= out_fire && out_eot;
      if (out_fire && M_AXIS_TLAST) pkt_count <= pkt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_srio_swrite_chunker.sv
// Scoreboard bench for srio_swrite_chunker: segment model, random valid/ready, reset mid-segment.
module tb_srio_swrite_chunker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b1;
  logic [5:0]  cfg = 6'd4;
  logic [15:0] pkt_count;
  logic        xfer_done;

  always #5 clk = ~clk;

  srio_swrite_chunker dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESETN (rst_n),
    .S_AXIS_TDATA (s_tdata),
    .S_AXIS_TVALID(s_tvalid),
    .S_AXIS_TLAST (s_tlast),
    .S_AXIS_TREADY(s_tready),
    .M_AXIS_TDATA (m_tdata),
    .M_AXIS_TVALID(m_tvalid),
    .M_AXIS_TLAST (m_tlast),
    .M_AXIS_TREADY(m_tready),
    .cfg_max_beats(cfg),
    .pkt_count    (pkt_count),
    .xfer_done    (xfer_done)
  );

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic        eot;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    exp_pkt = 0;
  int    seg_model = 0;
  int    exp_done_total = 0;
  int    seen_done = 0;
  int    cyc = 0;
  int    first_fire = -1;
  int    last_fire = -1;
  bit    pend_done = 1'b0;
  bit    in_reset = 1'b1;
  bit    rand_ready = 1'b0;
  bit    force_ready = 1'b1;
  bit    hold_v = 1'b0;
  beat_t hold_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic int eff(input logic [5:0] c);
    return ((c == 6'd0) || (c > 6'd32)) ? 32 : int'(c);
  endfunction

  // Segments of l1 beats while the segment starts before beat k, l2 afterwards.
  function automatic int push_xfer(input int n, input logic [63:0] base,
                                   input int l1, input int k, input int l2);
    int s = 0;
    int segs = 0;
    while (s < n) begin
      int lim;
      int len;
      lim = (s < k) ? l1 : l2;
      len = ((n - s) < lim) ? (n - s) : lim;
      for (int i = 0; i < len; i++) begin
        beat_t b;
        b.data = base + 64'(s + i);
        b.last = (i == len - 1);
        b.eot  = (s + i == n - 1);
        exp_q.push_back(b);
      end
      s += len;
      segs++;
    end
    return segs;
  endfunction

  // Sole driver of m_tready.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
    end
  end

  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (!in_reset) begin
      check("xfer_done_timing", 64'(xfer_done), 64'(pend_done));
      check("pkt_count_live", 64'(pkt_count), 64'(16'(exp_pkt)));
      if (xfer_done) seen_done++;
      if (hold_v) begin
        check("stall_valid", 64'(m_tvalid), 64'(1'b1));
        check("stall_data", m_tdata, hold_b.data);
        check("stall_last", 64'(m_tlast), 64'(hold_b.last));
      end
      pend_done = 1'b0;
      hold_v    = 1'b0;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h, expected no beat", m_tdata);
        end else begin
          e = exp_q.pop_front();
          check("out_data", m_tdata, e.data);
          check("out_last", 64'(m_tlast), 64'(e.last));
          if (e.last) exp_pkt++;
          pend_done = e.eot;
          if (first_fire < 0) first_fire = cyc;
          last_fire = cyc;
        end
      end else if (m_tvalid) begin
        hold_v      = 1'b1;
        hold_b.data = m_tdata;
        hold_b.last = m_tlast;
        hold_b.eot  = 1'b0;
      end
    end
  end

  task automatic wait_accept();
    int t = 0;
    bit ok = 1'b0;
    do begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 500);
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: tready low for %0d cycles, expected accept", t);
    end
  endtask

  task automatic send_xfer(input int n, input logic [63:0] base, input int gap_pct,
                           input int k, input logic [5:0] cfg2);
    seg_model += push_xfer(n, base, eff(cfg), k, eff(cfg2));
    exp_done_total++;
    for (int i = 0; i < n; i++) begin
      if (i == k) cfg = cfg2;
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        s_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = base + 64'(i);
      s_tlast  = (i == n - 1);
      wait_accept();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d beats outstanding, expected 0", name, exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_tready"}, 64'(s_tready), 64'(1'b0));
    check({tag, "_m_tvalid"}, 64'(m_tvalid), 64'(1'b0));
    check({tag, "_m_tlast"},  64'(m_tlast),  64'(1'b0));
    check({tag, "_m_tdata"},  m_tdata,       64'(0));
    check({tag, "_pkt_count"}, 64'(pkt_count), 64'(0));
    check({tag, "_xfer_done"}, 64'(xfer_done), 64'(0));
  endtask

  task automatic release_reset(input string tag);
    @(negedge clk);
    rst_n    = 1'b1;
    in_reset = 1'b0;
    #1;
    check({tag, "_tready_held_low"}, 64'(s_tready), 64'(1'b0));
    @(posedge clk);
    #1;
    check({tag, "_tready_rises"}, 64'(s_tready), 64'(1'b1));
  endtask

  initial begin
    int d0;
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
    d0 = 0;
  end

  initial begin
    int d0;
    #12;
    check_reset_outputs("reset");
    release_reset("rel1");

    // 1: 10 beats at L=4, full throughput
    cfg = 6'd4;
    d0 = seen_done;
    first_fire = -1;
    send_xfer(10, 64'h100, 0, 10, 6'd4);
    drain("t1");
    check("t1_pkt_count", 64'(pkt_count), 64'(3));
    check("t1_done", 64'(seen_done - d0), 64'(1));
    check("t1_no_bubbles", 64'(last_fire - first_fire), 64'(9));

    // 2: L=MAX via cfg=0, 64 beats of 0..63
    cfg = 6'd0;
    d0 = seen_done;
    send_xfer(64, 64'h0, 0, 64, 6'd0);
    drain("t2");
    check("t2_pkt_count", 64'(pkt_count), 64'(5));
    check("t2_done", 64'(seen_done - d0), 64'(1));

    // 3: single-beat then 16-beat transfer at L=8
    cfg = 6'd8;
    d0 = seen_done;
    send_xfer(1, 64'h5000, 0, 1, 6'd8);
    send_xfer(16, 64'h6000, 0, 16, 6'd8);
    drain("t3");
    check("t3_pkt_count", 64'(pkt_count), 64'(8));
    check("t3_done", 64'(seen_done - d0), 64'(2));

    // 4: random valid and ready, L=5, 23 beats
    cfg = 6'd5;
    rand_ready = 1'b1;
    d0 = seen_done;
    send_xfer(23, 64'h7000, 40, 23, 6'd5);
    drain("t4");
    check("t4_pkt_count", 64'(pkt_count), 64'(13));
    check("t4_done", 64'(seen_done - d0), 64'(1));
    rand_ready = 1'b0;

    // 5: cfg 4->2 before beat 2: segments 4,2,2,2
    cfg = 6'd4;
    send_xfer(10, 64'h8000, 0, 2, 6'd2);
    drain("t5");
    check("t5_pkt_count", 64'(pkt_count), 64'(17));

    // Boundaries: L=1 and an oversized cfg
    cfg = 6'd1;
    send_xfer(3, 64'h9000, 0, 3, 6'd1);
    cfg = 6'd40;
    send_xfer(35, 64'hA000, 0, 35, 6'd40);
    drain("bound");
    check("bound_pkt_count", 64'(pkt_count), 64'(22));

    // Random transfers
    rand_ready = 1'b1;
    for (int r = 0; r < 8; r++) begin
      cfg = 6'($urandom_range(0, 63));
      send_xfer(int'($urandom_range(1, 40)), {$urandom, $urandom}, 30, 1000, 6'd0);
    end
    drain("rand");
    rand_ready = 1'b0;
    check("rand_pkt_count", 64'(pkt_count), 64'(16'(seg_model)));
    check("rand_done_total", 64'(seen_done), 64'(exp_done_total));

    // 6: async reset mid-segment with input stalled
    force_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cfg = 6'd4;
    s_tvalid = 1'b1;
    s_tlast  = 1'b0;
    s_tdata  = 64'hDEAD_0000;
    wait_accept();
    s_tdata = 64'hDEAD_0001;
    wait_accept();
    s_tdata = 64'hDEAD_0002;
    @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    s_tvalid = 1'b0;
    exp_q.delete();
    exp_pkt   = 0;
    pend_done = 1'b0;
    hold_v    = 1'b0;
    seg_model = 0;
    seen_done = 0;
    force_ready = 1'b1;
    repeat (2) @(posedge clk);
    release_reset("rel2");
    cfg = 6'd4;
    send_xfer(3, 64'hB000, 0, 3, 6'd4);
    drain("t6");
    check("t6_pkt_count", 64'(pkt_count), 64'(1));
    check("t6_done", 64'(seen_done), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
    d0 = 0;
  end

endmodule
